stack_exec: RTL and testbench



---
 rtl/stack_exec.sv | 217 +++++++++++++++++++++
 tb/tb_stack_exec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_exec.sv
// stack_exec: stack-machine opcode sequencer; breaks each accepted opcode into
// peek/pop/push/poke micro-operations on the attached LIFO and returns one response.
module stack_exec #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 256,
   localparam int unsigned IW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             stk_push_en,
   output logic             stk_pop_en,
   output logic             stk_peek_en,
   output logic             stk_poke_en,
   output logic [WIDTH-1:0] stk_data_in,
   output logic [IW-1:0]    stk_index,
   input  logic [WIDTH-1:0] stk_data_out,
   input  logic             stk_full,
   input  logic             stk_empty,
   input  logic [IW-1:0]    stk_depth
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LIT  = 4'd1;
   localparam logic [3:0] OP_DROP = 4'd2;
   localparam logic [3:0] OP_DUP  = 4'd3;
   localparam logic [3:0] OP_SWAP = 4'd4;
   localparam logic [3:0] OP_OVER = 4'd5;
   localparam logic [3:0] OP_ADD  = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_PEEK = 4'd11;

   typedef enum logic [3:0] {
      S_IDLE, S_RD0, S_RDN, S_RD1, S_CAPA, S_CAPB,
      S_PUSH, S_POP, S_POKE0, S_POKE1, S_RESP
   } state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] arg_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic             pre_ok;
   logic [IW-1:0]    cmd_idx;
   logic [WIDTH-1:0] alu_r;
   logic [WIDTH-1:0] push_val;
   logic             is_alu;

   assign cmd_ready = (state == S_IDLE);
   assign cmd_idx   = IW'(cmd_arg);
   assign is_alu    = (op_q >= OP_ADD) && (op_q <= OP_XOR);

   // Acceptance precheck: operand count, free space and peek range
   always_comb begin
      logic need1, need2, need_room, legal;
      need1     = 1'b0;
      need2     = 1'b0;
      need_room = 1'b0;
      legal     = 1'b1;
      case (cmd_op)
         OP_NOP, OP_PEEK: ;
         OP_LIT:  need_room = 1'b1;
         OP_DROP: need1 = 1'b1;
         OP_DUP:  begin need1 = 1'b1; need_room = 1'b1; end
         OP_OVER: begin need2 = 1'b1; need_room = 1'b1; end
         OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: need2 = 1'b1;
         default: legal = 1'b0;
      endcase
      pre_ok = legal
             && !(need1 && stk_empty)
             && !(need2 && (stk_depth < IW'(2)))
             && !(need_room && stk_full)
             && !((cmd_op == OP_PEEK) && (cmd_idx >= stk_depth));
   end

   // ALU result from next (B) and top (A), wrapping
   always_comb begin
      alu_r = '0;
      case (op_q)
         OP_ADD:  alu_r = b_q + a_q;
         OP_SUB:  alu_r = b_q - a_q;
         OP_AND:  alu_r = b_q & a_q;
         OP_OR:   alu_r = b_q | a_q;
         OP_XOR:  alu_r = b_q ^ a_q;
         default: alu_r = '0;
      endcase
   end

   // Value pushed: literal for LIT, top for DUP, next for OVER
   always_comb begin
      push_val = b_q;
      if (op_q == OP_LIT)      push_val = arg_q;
      else if (op_q == OP_DUP) push_val = a_q;
   end

   // Stack strobes decoded from the micro-state
   always_comb begin
      stk_push_en = 1'b0;
      stk_pop_en  = 1'b0;
      stk_peek_en = 1'b0;
      stk_poke_en = 1'b0;
      stk_data_in = '0;
      stk_index   = '0;
      case (state)
         S_RD0:   stk_peek_en = 1'b1;
         S_RDN:   begin stk_peek_en = 1'b1; stk_index = IW'(arg_q); end
         S_RD1:   begin stk_peek_en = 1'b1; stk_index = IW'(1); end
         S_PUSH:  begin stk_push_en = 1'b1; stk_data_in = push_val; end
         S_POP:   stk_pop_en = 1'b1;
         S_POKE0: begin
            stk_poke_en = 1'b1;
            stk_data_in = (op_q == OP_SWAP) ? b_q : alu_r;
         end
         S_POKE1: begin stk_poke_en = 1'b1; stk_index = IW'(1); stk_data_in = a_q; end
         default: ;
      endcase
   end

   // Sequencer FSM with registered response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         arg_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: if (cmd_valid) begin
               op_q  <= cmd_op;
               arg_q <= cmd_arg;
               if (!pre_ok || cmd_op == OP_NOP) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !pre_ok;
                  rsp_data  <= '0;
               end else if (cmd_op == OP_LIT) begin
                  state <= S_PUSH;
               end else if (cmd_op == OP_PEEK) begin
                  state <= S_RDN;
               end else begin
                  state <= S_RD0;
               end
            end
            S_RD0: state <= (op_q == OP_DROP || op_q == OP_DUP) ? S_CAPA : S_RD1;
            S_RDN: state <= S_CAPA;
            S_RD1: begin
               a_q   <= stk_data_out;
               state <= S_CAPB;
            end
            S_CAPA: begin
               a_q <= stk_data_out;
               if (op_q == OP_DROP)     state <= S_POP;
               else if (op_q == OP_DUP) state <= S_PUSH;
               else begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= stk_data_out;
               end
            end
            S_CAPB: begin
               b_q <= stk_data_out;
               if (op_q == OP_OVER)      state <= S_PUSH;
               else if (op_q == OP_SWAP) state <= S_POKE0;
               else                      state <= S_POP;
            end
            S_PUSH: begin
               state     <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= push_val;
            end
            S_POP: begin
               if (is_alu) state <= S_POKE0;
               else begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= a_q;
               end
            end
            S_POKE0: begin
               if (op_q == OP_SWAP) state <= S_POKE1;
               else begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= alu_r;
               end
            end
            S_POKE1: begin
               state     <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= b_q;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_exec.sv
// tb_stack_exec: directed bench for stack_exec with a behavioural LIFO attached.
module tb_stack_exec;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned IW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             stk_push_en, stk_pop_en, stk_peek_en, stk_poke_en;
   logic [WIDTH-1:0] stk_data_in;
   logic [IW-1:0]    stk_index;
   logic [WIDTH-1:0] stk_data_out;
   logic             stk_full, stk_empty;
   logic [IW-1:0]    stk_depth;
   logic [3:0]       strb;

   typedef struct {
      logic             err;
      logic [WIDTH-1:0] data;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   stack_exec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en),
      .stk_peek_en(stk_peek_en), .stk_poke_en(stk_poke_en),
      .stk_data_in(stk_data_in), .stk_index(stk_index), .stk_data_out(stk_data_out),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_depth(stk_depth)
   );

   // Behavioural LIFO: mem[0] is bottom, registered peek read
   logic [WIDTH-1:0] mem [DEPTH];
   int               depth_m;
   assign stk_depth = IW'(depth_m);
   assign stk_full  = (depth_m == DEPTH);
   assign stk_empty = (depth_m == 0);
   assign strb      = {stk_push_en, stk_pop_en, stk_peek_en, stk_poke_en};

   always @(posedge clk) begin
      if (!rst_n) begin
         depth_m      <= 0;
         stk_data_out <= '0;
      end else begin
         if (stk_push_en && depth_m < DEPTH) begin
            mem[depth_m] <= stk_data_in;
            depth_m      <= depth_m + 1;
         end
         if (stk_pop_en && depth_m > 0) depth_m <= depth_m - 1;
         if (stk_peek_en && int'(stk_index) < depth_m)
            stk_data_out <= mem[depth_m - 1 - int'(stk_index)];
         if (stk_poke_en && int'(stk_index) < depth_m)
            mem[depth_m - 1 - int'(stk_index)] <= stk_data_in;
      end
   end

   function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   // Every cycle: at most one strobe, and never one the stack would have to ignore
   always @(negedge clk) begin
      if (rst_n) begin
         logic bad;
         bad = (stk_push_en && stk_full) || (stk_pop_en && stk_empty)
            || ((stk_peek_en || stk_poke_en) && (stk_index >= stk_depth));
         check("strobe_onehot", 32'($countones(strb) <= 1), 32'(1));
         check("strobe_legal", 32'(bad), 32'(0));
      end
   end

   task automatic do_cmd(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] arg,
                         input logic err, input logic [WIDTH-1:0] data, input int lat);
      exp_t e;
      int   k;
      logic any;
      @(negedge clk);
      check({tag, "_ready"}, 32'(cmd_ready), 32'(1));
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      sb.push_back('{err, data, lat});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_arg   = '0;
      k   = 1;
      any = 1'b0;
      while (!rsp_valid && k < 20) begin
         any = any | (strb != 0);
         @(posedge clk); #1;
         k++;
      end
      any = any | (strb != 0);
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(rsp_valid), 32'(1));
      if (rsp_valid) begin
         check({tag, "_lat"}, 32'(k), 32'(e.lat));
         check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
         check({tag, "_data"}, 32'(rsp_data), 32'(e.data));
         if (e.err) check({tag, "_nostrobe"}, 32'(any), 32'(0));
      end
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(rsp_valid), 32'(0));
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_arg   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(rsp_valid), 32'(0));
      check("rst_data", 32'(rsp_data), 32'(0));
      check("rst_err", 32'(rsp_err), 32'(0));
      check("rst_strobes", 32'(strb), 32'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 32'(cmd_ready), 32'(1));

      // Basic literal and subtract
      do_cmd("lit5", 4'd1, 8'd5, 1'b0, 8'd5, 2);
      do_cmd("lit3", 4'd1, 8'd3, 1'b0, 8'd3, 2);
      do_cmd("sub", 4'd7, 8'd0, 1'b0, 8'd2, 6);
      check("depth_a", 32'(stk_depth), 32'(1));

      // Underflow and illegal op
      do_cmd("add_under", 4'd6, 8'd0, 1'b1, 8'd0, 1);
      check("depth_b", 32'(stk_depth), 32'(1));
      do_cmd("op13", 4'd13, 8'd0, 1'b1, 8'd0, 1);

      // Fill to capacity, overflow checks, DROP, OVER
      do_cmd("drop2", 4'd2, 8'd0, 1'b0, 8'd2, 4);
      for (int i = 1; i <= 4; i++) do_cmd("fill", 4'd1, 8'(i), 1'b0, 8'(i), 2);
      do_cmd("dup_full", 4'd3, 8'd0, 1'b1, 8'd0, 1);
      do_cmd("lit_full", 4'd1, 8'd9, 1'b1, 8'd0, 1);
      check("depth_c", 32'(stk_depth), 32'(4));
      do_cmd("drop4", 4'd2, 8'd0, 1'b0, 8'd4, 4);
      check("depth_d", 32'(stk_depth), 32'(3));
      do_cmd("over", 4'd5, 8'd0, 1'b0, 8'd2, 5);
      check("depth_e", 32'(stk_depth), 32'(4));

      // Empty out; stack was [1,2,3,2(top)]
      do_cmd("dr_a", 4'd2, 8'd0, 1'b0, 8'd2, 4);
      do_cmd("dr_b", 4'd2, 8'd0, 1'b0, 8'd3, 4);
      do_cmd("dr_c", 4'd2, 8'd0, 1'b0, 8'd2, 4);
      do_cmd("dr_d", 4'd2, 8'd0, 1'b0, 8'd1, 4);
      do_cmd("drop_empty", 4'd2, 8'd0, 1'b1, 8'd0, 1);

      // SWAP and PEEK
      do_cmd("lit9", 4'd1, 8'd9, 1'b0, 8'd9, 2);
      do_cmd("lit7", 4'd1, 8'd7, 1'b0, 8'd7, 2);
      do_cmd("swap", 4'd4, 8'd0, 1'b0, 8'd9, 6);
      do_cmd("peek0", 4'd11, 8'd0, 1'b0, 8'd9, 3);
      do_cmd("peek1", 4'd11, 8'd1, 1'b0, 8'd7, 3);
      do_cmd("peek2", 4'd11, 8'd2, 1'b1, 8'd0, 1);
      check("depth_f", 32'(stk_depth), 32'(2));

      // ALU wrap and corner cases; stack [7,9]
      do_cmd("litff", 4'd1, 8'hFF, 1'b0, 8'hFF, 2);
      do_cmd("lit02", 4'd1, 8'h02, 1'b0, 8'h02, 2);
      do_cmd("add_wrap", 4'd6, 8'd0, 1'b0, 8'h01, 6);
      do_cmd("lit00", 4'd1, 8'h00, 1'b0, 8'h00, 2);
      do_cmd("sub_zero", 4'd7, 8'd0, 1'b0, 8'h01, 6);
      do_cmd("dup1", 4'd3, 8'd0, 1'b0, 8'h01, 4);
      do_cmd("xor_eq", 4'd10, 8'd0, 1'b0, 8'h00, 6);
      do_cmd("or", 4'd9, 8'd0, 1'b0, 8'h09, 6);
      do_cmd("and", 4'd8, 8'd0, 1'b0, 8'h01, 6);
      do_cmd("nop", 4'd0, 8'd0, 1'b0, 8'h00, 1);
      do_cmd("peek_top", 4'd11, 8'd0, 1'b0, 8'h01, 3);
      check("depth_g", 32'(stk_depth), 32'(1));

      // Reset in the middle of an ADD at POKE0
      do_cmd("lit5b", 4'd1, 8'd5, 1'b0, 8'd5, 2);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 4'd6;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_poke0", 32'(stk_poke_en), 32'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_strobes", 32'(strb), 32'(0));
      check("mid_valid", 32'(rsp_valid), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_ready", 32'(cmd_ready), 32'(1));
      check("post_depth", 32'(stk_depth), 32'(0));
      check("post_valid", 32'(rsp_valid), 32'(0));
      do_cmd("post_lit", 4'd1, 8'd6, 1'b0, 8'd6, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
